// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle SLL/SRL/SRA unit, at most STEP bit positions per cycle
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-high reset
//   in_valid, in_ready  operation handshake; in_ready is high only in IDLE
//   in, shamt, op       operand, shift amount (low SHW bits), 00 SLL 01 SRL 11 SRA 10 SLL
//   out_valid, out_ready, out  result handshake; out holds until the next result or reset
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] shamt,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);
    localparam int SHW = $clog2(WIDTH);
    // one extra bit so STEP == WIDTH still fits
    localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] data, data_nxt, sll, srl, sra;
    logic [SHW-1:0]   rem, rem_nxt;
    logic [1:0]       op_q, op_nxt;
    logic [SHW:0]     s;
    assign in_ready = (state == IDLE);
    assign s   = ({1'b0, rem} < STEP_W) ? {1'b0, rem} : STEP_W;
    assign sll = data << s;
    assign srl = data >> s;
    // kept out of any ternary so the signed context survives and MSB fill happens
    assign sra = $signed(data) >>> s;
    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        rem_nxt   = rem;
        op_nxt    = op_q;
        case (state)
            IDLE: if (in_valid) begin
                data_nxt  = in;
                rem_nxt   = shamt[SHW-1:0];
                op_nxt    = op;
                state_nxt = (shamt[SHW-1:0] == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                data_nxt  = op_q[0] ? (op_q[1] ? sra : srl) : sll;
                rem_nxt   = rem - s[SHW-1:0];
                state_nxt = (rem_nxt == '0) ? DONE : SHIFT;
            end
            DONE: state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data      <= '0;
            rem       <= '0;
            op_q      <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            data      <= data_nxt;
            rem       <= rem_nxt;
            op_q      <= op_nxt;
            out_valid <= (state_nxt == DONE);
            // capture the result only on entry to DONE so out stays put afterwards
            if (state != DONE && state_nxt == DONE) out <= data_nxt;
        end
    end
endmodule
